// File: rtl/riscv_boot_ctrl_if.sv
// Program-load and instruction-memory write bus between the boot sequencer
// (slave) and the word source / instruction ROM (master).
interface riscv_boot_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport slave  (input  wr_valid, wr_data,
                  output wr_ready, imem_we, imem_addr, imem_wdata);
  modport master (output wr_valid, wr_data,
                  input  wr_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: loads program words into imem with the core held in reset,
// then runs the core for a bounded number of cycles. Optional macro: BOOT_CHECKSUM_EN.
module riscv_boot_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int RUN_LIMIT = 1000,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               stop,
  riscv_boot_ctrl_if.slave   bus,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   run_cnt,
  output logic [DATA_W-1:0]  checksum
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(RUN_LIMIT - 1);
  localparam bit               LIMIT_EN = (RUN_LIMIT != 0);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, wcnt_q, wcnt_d;
  logic              rdy_q, rdy_d, we_q, we_d, crst_q, crst_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              xfer;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
`endif

  assign xfer = bus.wr_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    rdy_d   = rdy_q;
    we_d    = 1'b0;
    crst_d  = crst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rcnt_d  = rcnt_q;
`ifdef BOOT_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          if (prog_len != '0 && prog_len <= DEPTH) begin
            state_d = LOAD;
            len_d   = prog_len;
            wcnt_d  = '0;
            rdy_d   = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            rcnt_d  = '0;
`ifdef BOOT_CHECKSUM_EN
            chk_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = bus.wr_data;
          wcnt_d  = wcnt_q + (ADDR_W+1)'(1);
`ifdef BOOT_CHECKSUM_EN
          chk_d   = chk_q + bus.wr_data;
`endif
          // Drop ready together with the last strobe so no extra word slips in.
          if (wcnt_q == len_q - (ADDR_W+1)'(1)) begin
            rdy_d   = 1'b0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        crst_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (rcnt_q != '1) rcnt_d = rcnt_q + CNT_W'(1);
        if (stop || (LIMIT_EN && rcnt_q == LIMIT_M1)) begin
          state_d = HALT;
          crst_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        crst_d  = 1'b0;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      crst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rcnt_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rcnt_q  <= rcnt_d;
`ifdef BOOT_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.wr_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst_n     = crst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign run_cnt        = rcnt_q;
`ifdef BOOT_CHECKSUM_EN
  assign checksum       = chk_q;
`else
  assign checksum       = '0;
`endif
endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Directed bench for riscv_boot_ctrl: per-cycle vector table plus hand sequences
// for run length, stop, and reset-in-RUN.
module tb_riscv_boot_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIM = 10;

  typedef struct {
    logic        rstn, start, stop, vld;
    logic [AW:0] len;
    logic [31:0] data;
    logic        e_rdy, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_crst, e_busy, e_done, e_err;
    logic [31:0] e_cnt, e_chk;
  } vec_t;

  logic          clk = 1'b0;
  logic          areset, start, stop;
  logic [AW:0]   prog_len;
  logic          core_rst_n, busy, done, err;
  logic [31:0]   run_cnt, checksum;
  int            checks = 0;
  int            failures = 0;
  vec_t          tv [0:14];

  riscv_boot_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  riscv_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RUN_LIMIT(LIM), .CNT_W(32)) dut (
    .clk(clk), .areset(areset), .start(start), .prog_len(prog_len), .stop(stop),
    .bus(bus), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err),
    .run_cnt(run_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W0 = 32'h00500093, W1 = 32'h00A00113, W2 = 32'h002081B3;
  localparam logic [31:0] WA = 32'h11112222, WB = 32'h33334444, WX = 32'hDEADBEEF;

  function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef BOOT_CHECKSUM_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  function automatic vec_t mk(input logic rstn, start, input logic [AW:0] len,
                              input logic stop, vld, input logic [31:0] data,
                              input logic rdy, we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic crst, bsy, dn, er,
                              input logic [31:0] cnt, chk);
    vec_t v;
    v.rstn = rstn; v.start = start; v.len = len; v.stop = stop; v.vld = vld; v.data = data;
    v.e_rdy = rdy; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata; v.e_crst = crst;
    v.e_busy = bsy; v.e_done = dn; v.e_err = er; v.e_cnt = cnt; v.e_chk = chk;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rstn, st, input logic [AW:0] len, input logic sp, vld,
                       input logic [31:0] data);
    areset = rstn; start = st; prog_len = len; stop = sp;
    bus.wr_valid = vld; bus.wr_data = data;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tv[i].rstn, tv[i].start, tv[i].len, tv[i].stop, tv[i].vld, tv[i].data);
      step();
      cmp($sformatf("r%0d.wr_ready", i), 32'(bus.wr_ready), 32'(tv[i].e_rdy));
      cmp($sformatf("r%0d.imem_we", i), 32'(bus.imem_we), 32'(tv[i].e_we));
      cmp($sformatf("r%0d.imem_addr", i), 32'(bus.imem_addr), 32'(tv[i].e_addr));
      cmp($sformatf("r%0d.imem_wdata", i), bus.imem_wdata, tv[i].e_wdata);
      cmp($sformatf("r%0d.core_rst_n", i), 32'(core_rst_n), 32'(tv[i].e_crst));
      cmp($sformatf("r%0d.busy", i), 32'(busy), 32'(tv[i].e_busy));
      cmp($sformatf("r%0d.done", i), 32'(done), 32'(tv[i].e_done));
      cmp($sformatf("r%0d.err", i), 32'(err), 32'(tv[i].e_err));
      cmp($sformatf("r%0d.run_cnt", i), run_cnt, tv[i].e_cnt);
      cmp($sformatf("r%0d.checksum", i), checksum, tv[i].e_chk);
    end
  endtask

  initial begin
    int high;
    logic [31:0] s3, sab;
    s3  = W0 + W1 + W2;
    sab = WA + WB;
    //           rstn st len stp vld data   rdy we adr wdata crst bsy dn er cnt chk
    tv[0]  = mk(0, 0, 6'd0,  0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0,  0);
    tv[1]  = mk(1, 1, 6'd3,  0, 0, 0,     1, 0, 0, 0,  0, 1, 0, 0, 0,  0);
    tv[2]  = mk(1, 0, 6'd0,  0, 1, W0,    1, 1, 0, W0, 0, 1, 0, 0, 0,  cs(W0));
    tv[3]  = mk(1, 0, 6'd0,  0, 1, W1,    1, 1, 1, W1, 0, 1, 0, 0, 0,  cs(W0 + W1));
    tv[4]  = mk(1, 0, 6'd0,  0, 1, W2,    0, 1, 2, W2, 0, 1, 0, 0, 0,  cs(s3));
    tv[5]  = mk(1, 0, 6'd0,  0, 1, WX,    0, 0, 2, W2, 1, 1, 0, 0, 0,  cs(s3));
    // from HALT (done=1, run_cnt=10): illegal starts, then a legal one
    tv[6]  = mk(1, 1, 6'd0,  0, 0, 0,     0, 0, 2, W2, 0, 0, 1, 1, 10, cs(s3));
    tv[7]  = mk(1, 0, 6'd0,  0, 0, 0,     0, 0, 2, W2, 0, 0, 1, 1, 10, cs(s3));
    tv[8]  = mk(1, 1, 6'd33, 0, 1, WX,    0, 0, 2, W2, 0, 0, 1, 1, 10, cs(s3));
    tv[9]  = mk(1, 1, 6'd2,  0, 0, 0,     1, 0, 2, W2, 0, 1, 0, 0, 0,  0);
    tv[10] = mk(1, 0, 6'd0,  0, 1, WA,    1, 1, 0, WA, 0, 1, 0, 0, 0,  cs(WA));
    tv[11] = mk(1, 0, 6'd0,  0, 0, WX,    1, 0, 0, WA, 0, 1, 0, 0, 0,  cs(WA));
    tv[12] = mk(1, 0, 6'd0,  0, 1, WB,    0, 1, 1, WB, 0, 1, 0, 0, 0,  cs(sab));
    tv[13] = mk(1, 0, 6'd0,  0, 1, WX,    0, 0, 1, WB, 1, 1, 0, 0, 0,  cs(sab));
    tv[14] = mk(1, 1, 6'd3,  0, 0, 0,     0, 0, 1, WB, 1, 1, 0, 0, 1,  cs(sab));

    drive(0, 0, '0, 0, 0, '0);
    step();
    run_rows(0, 5);

    // Core must see exactly LIM cycles of released reset, then halt.
    high = 1;
    drive(1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 50; i++) begin
      step();
      if (core_rst_n !== 1'b1) break;
      high++;
    end
    cmp("run_high_cycles", 32'(high), 32'(LIM));
    cmp("halt.done", 32'(done), 32'd1);
    cmp("halt.busy", 32'(busy), 32'd0);
    cmp("halt.run_cnt", run_cnt, 32'(LIM));
    cmp("halt.checksum", checksum, cs(s3));

    run_rows(6, 14);

    // stop at RUN cycle 4 wins over the limit
    drive(1, 0, '0, 0, 0, '0);
    step(); step(); step();
    cmp("pre_stop.run_cnt", run_cnt, 32'd4);
    drive(1, 0, '0, 1, 0, '0);
    step();
    cmp("stop.done", 32'(done), 32'd1);
    cmp("stop.core_rst_n", 32'(core_rst_n), 32'd0);
    cmp("stop.busy", 32'(busy), 32'd0);
    cmp("stop.run_cnt", run_cnt, 32'd5);

    // reset in the middle of RUN
    drive(1, 1, 6'd1, 0, 0, '0);
    step();
    drive(1, 0, '0, 0, 1, WX);
    step();
    cmp("ld1.imem_we", 32'(bus.imem_we), 32'd1);
    cmp("ld1.wr_ready", 32'(bus.wr_ready), 32'd0);
    drive(1, 0, '0, 0, 0, '0);
    step(); step(); step(); step();
    cmp("midrun.core_rst_n", 32'(core_rst_n), 32'd1);
    cmp("midrun.run_cnt", run_cnt, 32'd3);
    drive(0, 0, '0, 0, 0, '0);
    step();
    cmp("rst.core_rst_n", 32'(core_rst_n), 32'd0);
    cmp("rst.busy", 32'(busy), 32'd0);
    cmp("rst.done", 32'(done), 32'd0);
    cmp("rst.run_cnt", run_cnt, 32'd0);
    cmp("rst.imem_addr", 32'(bus.imem_addr), 32'd0);
    cmp("rst.checksum", checksum, 32'd0);

    // re-start after reset loads and runs to the limit
    drive(1, 1, 6'd1, 0, 0, '0);
    step();
    cmp("rl.wr_ready", 32'(bus.wr_ready), 32'd1);
    drive(1, 0, '0, 0, 1, WB);
    step();
    cmp("rl.imem_we", 32'(bus.imem_we), 32'd1);
    cmp("rl.imem_wdata", bus.imem_wdata, WB);
    drive(1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 100; i++) begin
      step();
      if (done === 1'b1) break;
    end
    cmp("rl.done", 32'(done), 32'd1);
    cmp("rl.run_cnt", run_cnt, 32'(LIM));
    cmp("rl.core_rst_n", 32'(core_rst_n), 32'd0);
    cmp("rl.checksum", checksum, cs(WB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
